pipe_rr_arbiter: RTL and testbench
==================================

PIPE_RR_ARBITER -- requirements
Module: pipe_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 512, data width of every stream.
REQ-002 Parameter NUM_REQ, default 4, number of upstream requesters (range 2..16).
REQ-003 Derived localparam ID_W = max(1, clog2(NUM_REQ)); it is not overridable.
REQ-004 Port clk, input, 1, the single clock for all logic.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port us_valid, input, NUM_REQ, per-requester beat valid.
REQ-007 Port us_data, input, NUM_REQ x WIDTH, per-requester beat data.
REQ-008 Port us_last, input, NUM_REQ, per-requester end-of-packet marker.
REQ-009 Port us_ready, output, NUM_REQ, per-requester beat accept.
REQ-010 Port ds_valid, output, 1, merged beat valid.
REQ-011 Port ds_data, output, WIDTH, merged beat data.
REQ-012 Port ds_last, output, 1, merged end-of-packet marker.
REQ-013 Port ds_id, output, ID_W, index of the requester that sourced the ds beat.
REQ-014 Port ds_ready, input, 1, downstream accept.

Function
REQ-015 A beat transfers on a port in any cycle where valid and ready are both high; valid, data and last are held stable while valid is high and ready is low (upstream obligation, and required of ds).
REQ-016 The output is a single register stage with load_en = !ds_valid || ds_ready; latency from us acceptance to ds_valid is exactly 1 cycle; with ds_ready held high, sustained throughput is 1 beat/cycle.
REQ-017 The FSM has two states: IDLE (no packet in progress) and LOCKED (mid-packet on grant_idx).
REQ-018 In IDLE, the grant is the first requester with us_valid high, searching from rr_ptr upward modulo NUM_REQ; with no us_valid high, nothing is granted and the state holds.
REQ-019 In LOCKED, the grant is fixed at grant_idx regardless of other requesters' valid; if the granted requester drops us_valid, the arbiter waits and grants no other requester.
REQ-020 us_ready[i] = load_en AND (i == current grant) AND grant exists; at most one bit of us_ready is high in any cycle.
REQ-021 On an accepted beat with us_last=0: the next state is LOCKED and grant_idx is set to the granted index.
REQ-022 On an accepted beat with us_last=1: the next state is IDLE and rr_ptr = (granted index + 1) mod NUM_REQ.
REQ-023 A single-beat packet (last=1 on its first beat) accepted in IDLE leaves the state IDLE and advances rr_ptr.
REQ-024 The ds register loads data, last and id from the granted requester on acceptance; when load_en is high and no beat is accepted, ds_valid is cleared.
REQ-025 Fairness: rr_ptr only advances on a packet end, so an ever-valid requester waits at most NUM_REQ-1 packets.
REQ-026 ds_ready low for any duration stalls all upstream requesters with no beat lost or duplicated.

Reset
REQ-027 While rst is high at a clk edge: state=IDLE, rr_ptr=0, grant_idx=0, ds_valid=0, ds_last=0, ds_id=0.
REQ-028 ds_data is not reset.
REQ-029 us_ready is 0 in every cycle in which rst is high.
REQ-030 A reset mid-packet abandons the packet; after rst falls, arbitration restarts from requester 0, and no partial packet continues.

Structure
REQ-031 A shared package pipe_arb_pkg holds the FSM state enum (ARB_IDLE, ARB_LOCKED).
REQ-032 One combinational sub-module, rr_pick, takes req[NUM_REQ] and ptr[ID_W] and produces gnt_valid and gnt_idx using the rotate-priority search.
REQ-033 For timing, an existing pipe_adapter_mult instance may sit downstream of ds; this block contains no extra slices.

Verification (NUM_REQ=4, WIDTH=32)
REQ-034 After reset, us_valid=4'b1111, every packet 1 beat, ds_ready=1 -> ds_id sequence 0,1,2,3,0,... with one beat per cycle after 1-cycle latency.
REQ-035 Req1 sends a 3-beat packet (A,B,C) while req2 is continuously valid -> ds shows A,B,C with id=1, last only on C, then req2.
REQ-036 Req0 mid-packet drops us_valid for 2 cycles while req3 is valid -> us_ready[3] stays 0, ds_valid goes low, and req0 resumes and completes.
REQ-037 ds_ready=0 for 5 cycles with all requesters valid -> ds_data/ds_id/ds_last are held stable and us_ready=0; on release, there is no loss or duplication (scoreboard match).
REQ-038 rst pulsed during the 2nd beat of a 4-beat req2 packet -> ds_valid=0 the next cycle, and the first post-reset grant is the lowest valid index.
REQ-039 Random valid, last and ds_ready for 10k cycles -> per-requester order is preserved, us_ready is one-hot-or-zero, and no requester starves beyond 3 packets.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// rtl/pipe_arb_pkg.sv - shared FSM state and sizing helper for the packet arbiter
package pipe_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Index width never drops below one bit, even for two requesters.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority search: first set req at or above ptr, else wrap to lowest
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_idx
);

  logic            w_hi_valid;
  logic            w_lo_valid;
  logic [ID_W-1:0] w_hi_idx;
  logic [ID_W-1:0] w_lo_idx;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    w_hi_valid = 1'b0;
    w_lo_valid = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_valid = 1'b1;
        w_lo_idx   = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          w_hi_valid = 1'b1;
          w_hi_idx   = ID_W'(i);
        end
      end
    end
  end

  assign gnt_valid = w_lo_valid;
  assign gnt_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/pipe_rr_arbiter.sv
// rtl/pipe_rr_arbiter.sv - packet-atomic round-robin merge of NUM_REQ streams into one registered stream
module pipe_rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int  WIDTH   = 512,
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       us_valid,
  input  logic [NUM_REQ*WIDTH-1:0] us_data,
  input  logic [NUM_REQ-1:0]       us_last,
  output logic [NUM_REQ-1:0]       us_ready,
  output logic                     ds_valid,
  output logic [WIDTH-1:0]         ds_data,
  output logic                     ds_last,
  output logic [ID_W-1:0]          ds_id,
  input  logic                     ds_ready
);

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant_idx;
  logic             r_ds_valid;
  logic             r_ds_last;
  logic [ID_W-1:0]  r_ds_id;
  logic [WIDTH-1:0] r_ds_data;

  logic               w_load_en;
  logic               w_pick_valid;
  logic [ID_W-1:0]    w_pick_idx;
  logic               w_gnt_valid;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [WIDTH-1:0]   w_sel_data;
  logic [NUM_REQ-1:0] w_us_ready;
  logic               w_accept;
  logic [ID_W-1:0]    w_next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req       (us_valid),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_pick_valid),
    .gnt_idx   (w_pick_idx)
  );

  assign w_load_en = !r_ds_valid || ds_ready;

  // Mid-packet the grant stays put even if that requester bubbles.
  assign w_gnt_valid = (r_state == ARB_LOCKED) || w_pick_valid;
  assign w_gnt_idx   = (r_state == ARB_LOCKED) ? r_grant_idx : w_pick_idx;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_us_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_sel_valid   = us_valid[i];
        w_sel_last    = us_last[i];
        w_sel_data    = us_data[i*WIDTH +: WIDTH];
        w_us_ready[i] = w_load_en && w_gnt_valid && !rst;
      end
    end
  end

  assign w_accept   = w_load_en && w_gnt_valid && w_sel_valid && !rst;
  assign w_next_ptr = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_ds_valid  <= 1'b0;
      r_ds_last   <= 1'b0;
      r_ds_id     <= '0;
    end else begin
      if (w_load_en) begin
        r_ds_valid <= w_accept;
        if (w_accept) begin
          r_ds_last <= w_sel_last;
          r_ds_id   <= w_gnt_idx;
        end
      end
      // The round-robin pointer only moves on a packet end.
      if (w_accept) begin
        if (w_sel_last) begin
          r_state  <= ARB_IDLE;
          r_rr_ptr <= w_next_ptr;
        end else begin
          r_state     <= ARB_LOCKED;
          r_grant_idx <= w_gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ds_data <= w_sel_data;
    end
  end

  assign us_ready = w_us_ready;
  assign ds_valid = r_ds_valid;
  assign ds_data  = r_ds_data;
  assign ds_last  = r_ds_last;
  assign ds_id    = r_ds_id;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// tb/tb_pipe_rr_arbiter.sv - directed-vector bench for pipe_rr_arbiter (NUM_REQ=4, WIDTH=32)
module tb_pipe_rr_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       us_valid;
  logic [NUM_REQ*WIDTH-1:0] us_data;
  logic [NUM_REQ-1:0]       us_last;
  logic [NUM_REQ-1:0]       us_ready;
  logic                     ds_valid;
  logic [WIDTH-1:0]         ds_data;
  logic                     ds_last;
  logic [1:0]               ds_id;
  logic                     ds_ready;

  int total;
  int bad;

  pipe_rr_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .us_valid (us_valid),
    .us_data  (us_data),
    .us_last  (us_last),
    .us_ready (us_ready),
    .ds_valid (ds_valid),
    .ds_data  (ds_data),
    .ds_last  (ds_last),
    .ds_id    (ds_id),
    .ds_ready (ds_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1: drive, settle, check, then advance one clock.
  task automatic vec(input string tag, input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic [127:0] d, input logic dsr, input logic [3:0] erdy,
                     input logic edv, input logic [1:0] eid, input logic elast,
                     input logic [31:0] edata);
    rst      = r;
    us_valid = v;
    us_last  = l;
    us_data  = d;
    ds_ready = dsr;
    #1;
    check({tag, ".rdy"}, 64'(us_ready), 64'(erdy));
    check({tag, ".dv"}, 64'(ds_valid), 64'(edv));
    if (edv) begin
      check({tag, ".id"}, 64'(ds_id), 64'(eid));
      check({tag, ".last"}, 64'(ds_last), 64'(elast));
      check({tag, ".data"}, 64'(ds_data), 64'(edata));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    us_valid = 4'hF;
    us_last  = 4'hF;
    ds_ready = 1'b1;
    #1;
    check("rst.rdy_pre", 64'(us_ready), 64'h0);
    @(posedge clk);
    #1;
    check("rst.rdy", 64'(us_ready), 64'h0);
    check("rst.dv", 64'(ds_valid), 64'h0);
    check("rst.last", 64'(ds_last), 64'h0);
    check("rst.id", 64'(ds_id), 64'h0);
  endtask

  localparam logic [31:0] A0 = 32'hA000_0000;
  localparam logic [31:0] A1 = 32'hA000_0001;
  localparam logic [31:0] A2 = 32'hA000_0002;
  localparam logic [31:0] A3 = 32'hA000_0003;

  logic [127:0] d_all;
  logic [31:0]  exp_d;
  logic [1:0]   exp_id;
  logic [3:0]   exp_rdy;

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    us_valid = '0;
    us_last  = '0;
    us_data  = '0;
    ds_ready = 1'b1;
    d_all    = {A3, A2, A1, A0};
    @(posedge clk);
    #1;

    // Single-beat packets from everyone: ids rotate 0,1,2,3,0,1.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      exp_rdy = 4'(1 << (c % 4));
      exp_id  = (c > 0) ? 2'((c - 1) % 4) : 2'd0;
      exp_d   = A0 + 32'(exp_id);
      vec("rot", 1'b0, 4'hF, 4'hF, d_all, 1'b1, exp_rdy, c > 0, exp_id, 1'b1, exp_d);
    end
    vec("rot.drain", 1'b0, 4'h0, 4'hF, d_all, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, A1);
    vec("rot.idle", 1'b0, 4'h0, 4'hF, d_all, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);

    // Req1 3-beat packet A,B,C while req2 waits with single-beat D.
    do_reset();
    vec("p3.c0", 1'b0, 4'b0110, 4'b0100, {32'h0, 32'hDDDD, 32'hAAAA, 32'h0}, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 32'h0);
    vec("p3.c1", 1'b0, 4'b0110, 4'b0100, {32'h0, 32'hDDDD, 32'hBBBB, 32'h0}, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 32'hAAAA);
    vec("p3.c2", 1'b0, 4'b0110, 4'b0110, {32'h0, 32'hDDDD, 32'hCCCC, 32'h0}, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 32'hBBBB);
    vec("p3.c3", 1'b0, 4'b0100, 4'b0100, {32'h0, 32'hDDDD, 32'h0, 32'h0}, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1, 32'hCCCC);
    vec("p3.c4", 1'b0, 4'b0000, 4'b0000, 128'h0, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 32'hDDDD);
    vec("p3.c5", 1'b0, 4'b0000, 4'b0000, 128'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);

    // Req0 bubbles mid-packet; req3 must not be let in.
    do_reset();
    vec("bub.c0", 1'b0, 4'b1001, 4'b1000, {32'hEEEE, 64'h0, 32'h1000}, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 32'h0);
    vec("bub.c1", 1'b0, 4'b1000, 4'b1000, {32'hEEEE, 96'h0}, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 32'h1000);
    vec("bub.c2", 1'b0, 4'b1000, 4'b1000, {32'hEEEE, 96'h0}, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 32'h0);
    vec("bub.c3", 1'b0, 4'b1001, 4'b1000, {32'hEEEE, 64'h0, 32'h1001}, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 32'h0);
    vec("bub.c4", 1'b0, 4'b1001, 4'b1001, {32'hEEEE, 64'h0, 32'h1002}, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 32'h1001);
    vec("bub.c5", 1'b0, 4'b1000, 4'b1000, {32'hEEEE, 96'h0}, 1'b1, 4'b1000, 1'b1, 2'd0, 1'b1, 32'h1002);
    vec("bub.c6", 1'b0, 4'b0000, 4'b0000, 128'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, 32'hEEEE);
    vec("bub.c7", 1'b0, 4'b0000, 4'b0000, 128'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);

    // Five-cycle downstream stall with everyone valid.
    do_reset();
    vec("stl.c0", 1'b0, 4'hF, 4'hF, d_all, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 32'h0);
    vec("stl.c1", 1'b0, 4'hF, 4'hF, d_all, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1, A0);
    for (int c = 0; c < 5; c++) begin
      vec("stl.hold", 1'b0, 4'hF, 4'hF, d_all, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, A1);
    end
    vec("stl.c7", 1'b0, 4'hF, 4'hF, d_all, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1, A1);
    vec("stl.c8", 1'b0, 4'hF, 4'hF, d_all, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1, A2);
    vec("stl.c9", 1'b0, 4'h0, 4'hF, d_all, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, A3);
    vec("stl.c10", 1'b0, 4'h0, 4'hF, d_all, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);

    // Reset during the second beat of a req2 packet; req2 is abandoned.
    do_reset();
    vec("mrst.c0", 1'b0, 4'b1100, 4'b1000, {32'h3333, 32'h2000, 64'h0}, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 32'h0);
    vec("mrst.c1", 1'b1, 4'b1100, 4'b1000, {32'h3333, 32'h2001, 64'h0}, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 32'h2000);
    vec("mrst.c2", 1'b0, 4'b1010, 4'b1010, {32'h3333, 32'h0, 32'h1111, 32'h0}, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 32'h0);
    vec("mrst.c3", 1'b0, 4'b1000, 4'b1010, {32'h3333, 96'h0}, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1, 32'h1111);
    vec("mrst.c4", 1'b0, 4'b0000, 4'b0000, 128'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, 32'h3333);
    vec("mrst.c5", 1'b0, 4'b0000, 4'b0000, 128'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
